// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg: uop field widths, flow-control codes and sequencer FSM states
package dzcpu_useq_pkg;
    localparam int FLOW_W = 4;
    localparam int OP_W   = 5;
    localparam int SEL_W  = 4;
    localparam int UOP_W  = FLOW_W + OP_W + SEL_W;
    localparam logic [FLOW_W-1:0] F_OP         = 4'd0;
    localparam logic [FLOW_W-1:0] F_INC        = 4'd1;
    localparam logic [FLOW_W-1:0] F_EOF        = 4'd2;
    localparam logic [FLOW_W-1:0] F_INC_EOF    = 4'd3;
    localparam logic [FLOW_W-1:0] F_EOF_FU     = 4'd4;
    localparam logic [FLOW_W-1:0] F_INC_EOF_FU = 4'd5;
    localparam logic [FLOW_W-1:0] F_INC_EOF_Z  = 4'd6;
    localparam logic [FLOW_W-1:0] F_INC_EOF_NZ = 4'd7;
    localparam logic [FLOW_W-1:0] F_JCB        = 4'd8;
    typedef enum logic [1:0] {ST_FETCH, ST_DECODE, ST_EXEC} state_t;
endpackage

// File: rtl/dzcpu_useq_flowdec.sv
// dzcpu_useq_flowdec: decodes a uop flow code into issue/pc/flag/eof/jump strobes
//   flow      in  flow-control field of the current uop
//   z         in  datapath zero flag
//   stall     in  suppresses every strobe
//   valid     out uop op/sel issued
//   incpc     out PC += 1
//   fu        out commit ALU flags
//   eof       out last uop of the instruction
//   jump      out load uPC from the CB LUT
//   cond_skip out conditional eof taken, uop not issued
module dzcpu_useq_flowdec
    import dzcpu_useq_pkg::*;
(
    input  logic [FLOW_W-1:0] flow,
    input  logic              z,
    input  logic              stall,
    output logic              valid,
    output logic              incpc,
    output logic              fu,
    output logic              eof,
    output logic              jump,
    output logic              cond_skip
);
    logic skip, jcb;
    assign skip = (flow == F_INC_EOF_Z && z) || (flow == F_INC_EOF_NZ && !z);
    assign jcb  = flow == F_JCB;
    // Unknown codes fall through as plain op: issued, no other strobe.
    assign valid     = !stall && !skip && !jcb;
    assign incpc     = !stall && (flow inside {F_INC, F_INC_EOF, F_INC_EOF_FU, F_INC_EOF_Z, F_INC_EOF_NZ, F_JCB});
    assign fu        = !stall && (flow inside {F_EOF_FU, F_INC_EOF_FU});
    assign eof       = !stall && (skip || (flow inside {F_EOF, F_INC_EOF, F_EOF_FU, F_INC_EOF_FU}));
    assign jump      = !stall && jcb;
    assign cond_skip = !stall && skip;
endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq: dzcpu micro-sequencer; fetch opcode, map through LUTs, step ucode ROM, issue uops
//   iClock/iReset            clock, synchronous active-low reset
//   oFetchReq/iMemValid/iMemData  opcode fetch and CB-byte port
//   oMop/iFlowIdx            main flow LUT;  oCbMop/iCbFlowIdx  CB flow LUT
//   oUpc/iUop                ucode ROM address/data
//   iZeroFlag/iStall         datapath Z flag and busy
//   oUopValid/oOp/oSel/oIncPc/oUpdFlags/oEof  datapath strobes
//   oUcodeErr                sticky watchdog/uPC-wrap abort
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int UPC_W    = 8,
    parameter int MAX_UOPS = 32
) (
    input  logic             iClock,
    input  logic             iReset,
    output logic             oFetchReq,
    input  logic             iMemValid,
    input  logic [7:0]       iMemData,
    output logic [7:0]       oMop,
    input  logic [7:0]       iFlowIdx,
    output logic [7:0]       oCbMop,
    input  logic [7:0]       iCbFlowIdx,
    output logic [UPC_W-1:0] oUpc,
    input  logic [UOP_W-1:0] iUop,
    input  logic             iZeroFlag,
    input  logic             iStall,
    output logic             oUopValid,
    output logic [OP_W-1:0]  oOp,
    output logic [SEL_W-1:0] oSel,
    output logic             oIncPc,
    output logic             oUpdFlags,
    output logic             oEof,
    output logic             oUcodeErr
);
    localparam int WD_W = $clog2(MAX_UOPS) + 1;
    state_t            state;
    logic [7:0]        ir;
    logic [UPC_W-1:0]  upc;
    logic [WD_W-1:0]   wd;
    logic [FLOW_W-1:0] flow;
    logic ex, hold, d_valid, d_eof, d_jump, d_skip, abort;
    assign flow = iUop[UOP_W-1 -: FLOW_W];
    // Strobes are suppressed in the reset cycle and outside EXEC.
    assign ex   = iReset && state == ST_EXEC;
    // jcb needs the CB byte from memory; until it arrives it behaves like a stall.
    assign hold = iStall || (flow == F_JCB && !iMemValid);
    dzcpu_useq_flowdec u_flowdec (
        .flow(flow), .z(iZeroFlag), .stall(!ex || hold),
        .valid(d_valid), .incpc(oIncPc), .fu(oUpdFlags), .eof(d_eof),
        .jump(d_jump), .cond_skip(d_skip)
    );
    // Abort on the issuing uop that would exceed the budget or step uPC past its top.
    assign abort     = d_valid && !d_eof && (wd == WD_W'(MAX_UOPS - 1) || upc == '1);
    assign oEof      = d_eof || abort;
    assign oUopValid = d_valid;
    assign oOp       = iUop[SEL_W +: OP_W];
    assign oSel      = iUop[SEL_W-1:0];
    assign oFetchReq = iReset && state == ST_FETCH;
    assign oMop      = ir;
    assign oCbMop    = iMemData;
    assign oUpc      = upc;
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state     <= ST_FETCH;
            upc       <= '0;
            ir        <= '0;
            wd        <= '0;
            oUcodeErr <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (iMemValid) begin
                        ir    <= iMemData;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    upc   <= UPC_W'(iFlowIdx);
                    wd    <= '0;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (oEof) state <= ST_FETCH;
                    else if (d_jump) upc <= UPC_W'(iCbFlowIdx);
                    else if (!hold) upc <= upc + 1'b1;
                    if (d_valid) wd <= wd + 1'b1;
                    if (abort) oUcodeErr <= 1'b1;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_dzcpu_useq.sv
// tb_dzcpu_useq: directed self-checking bench for the dzcpu micro-sequencer
module tb_dzcpu_useq;
    import dzcpu_useq_pkg::*;
    logic iClock = 0, iReset = 0, iMemValid = 0, iZeroFlag = 0, iStall = 0;
    logic [7:0] iMemData = 0, iFlowIdx = 0, oMop, oCbMop, iCbFlowIdx;
    logic [7:0] oUpc;
    logic [12:0] iUop;
    logic oFetchReq, oUopValid, oIncPc, oUpdFlags, oEof, oUcodeErr;
    logic [4:0] oOp;
    logic [3:0] oSel;
    logic [12:0] rom [256];
    logic all_op = 0;
    int checks = 0, errors = 0;

    always #5 iClock = ~iClock;

    // Bench-side ucode ROM and CB LUT
    assign iUop       = all_op ? {F_OP, 9'd0} : rom[oUpc];
    assign iCbFlowIdx = (oCbMop == 8'h7C) ? 8'd16 : 8'd0;

    dzcpu_useq dut (
        .iClock(iClock), .iReset(iReset), .oFetchReq(oFetchReq), .iMemValid(iMemValid),
        .iMemData(iMemData), .oMop(oMop), .iFlowIdx(iFlowIdx), .oCbMop(oCbMop),
        .iCbFlowIdx(iCbFlowIdx), .oUpc(oUpc), .iUop(iUop), .iZeroFlag(iZeroFlag),
        .iStall(iStall), .oUopValid(oUopValid), .oOp(oOp), .oSel(oSel), .oIncPc(oIncPc),
        .oUpdFlags(oUpdFlags), .oEof(oEof), .oUcodeErr(oUcodeErr)
    );

    function automatic logic [12:0] mk(input logic [3:0] f, input int a);
        return {f, 5'(a), 4'h3};
    endfunction

    task automatic tick;
        @(posedge iClock);
        #1;
    endtask

    task automatic do_reset;
        iReset = 0;
        tick;
        iReset = 1;
    endtask

    // Wait for a fetch request, deliver the opcode, and return in the first EXEC cycle.
    task automatic do_fetch(input logic [7:0] op, input logic [7:0] idx);
        int n = 0;
        while (!oFetchReq && n < 10) begin tick; n++; end
        checks++;
        if (oFetchReq !== 1'b1) begin errors++; $display("FAIL fetch_timeout: oFetchReq=%b need 1", oFetchReq); end
        iMemData = op; iMemValid = 1; iFlowIdx = idx;
        tick;
        iMemValid = 0;
        #1;
        checks++;
        if (oMop !== op) begin errors++; $display("FAIL decode_mop: oMop=%h need %h", oMop, op); end
        tick;
    endtask

    task automatic test_reset;
        iReset = 0;
        tick; tick;
        checks++;
        if (oFetchReq !== 1'b0) begin errors++; $display("FAIL reset_fetchreq: %b need 0", oFetchReq); end
        checks++;
        if (oUcodeErr !== 1'b0) begin errors++; $display("FAIL reset_err: %b need 0", oUcodeErr); end
        iReset = 1;
        tick;
        checks++;
        if (oFetchReq !== 1'b1) begin errors++; $display("FAIL post_reset_fetchreq: %b need 1", oFetchReq); end
        checks++;
        if (oUopValid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: %b need 0", oUopValid); end
        checks++;
        if (oUpc !== 8'd0) begin errors++; $display("FAIL post_reset_upc: %0d need 0", oUpc); end
        checks++;
        if (oUcodeErr !== 1'b0) begin errors++; $display("FAIL post_reset_err: %b need 0", oUcodeErr); end
    endtask

    task automatic test_basic_seq;
        logic [7:0] eu [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
        logic ei [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic ee [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_fetch(8'h31, 8'd1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (oUpc !== eu[i]) begin errors++; $display("FAIL seq_upc[%0d]: %0d need %0d", i, oUpc, eu[i]); end
            checks++;
            if (oUopValid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: %b need 1", i, oUopValid); end
            checks++;
            if (oIncPc !== ei[i]) begin errors++; $display("FAIL seq_inc[%0d]: %b need %b", i, oIncPc, ei[i]); end
            checks++;
            if (oEof !== ee[i]) begin errors++; $display("FAIL seq_eof[%0d]: %b need %b", i, oEof, ee[i]); end
            checks++;
            if ({oOp, oSel} !== {eu[i][4:0], 4'h3}) begin errors++; $display("FAIL seq_opsel[%0d]: %h/%h need %h/3", i, oOp, oSel, eu[i][4:0]); end
            tick;
        end
        checks++;
        if (oFetchReq !== 1'b1) begin errors++; $display("FAIL seq_next_fetch: %b need 1", oFetchReq); end
    endtask

    task automatic test_cond_eof;
        logic ee [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic ei [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        iZeroFlag = 1;
        do_fetch(8'h20, 8'd19);
        checks++;
        if ({oUopValid, oIncPc, oEof} !== 3'b011) begin errors++; $display("FAIL jrnz_skip: v/i/e=%b%b%b need 011", oUopValid, oIncPc, oEof); end
        tick;
        checks++;
        if (oFetchReq !== 1'b1) begin errors++; $display("FAIL jrnz_skip_fetch: %b need 1", oFetchReq); end
        iZeroFlag = 0;
        do_fetch(8'h20, 8'd19);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({oUpc, oUopValid, oIncPc, oEof} !== {8'(19 + i), 1'b1, ei[i], ee[i]}) begin
                errors++; $display("FAIL jrnz_taken[%0d]: upc=%0d v/i/e=%b%b%b need %0d 1%b%b", i, oUpc, oUopValid, oIncPc, oEof, 19 + i, ei[i], ee[i]);
            end
            tick;
        end
        checks++;
        if (oFetchReq !== 1'b1) begin errors++; $display("FAIL jrnz_taken_fetch: %b need 1", oFetchReq); end
    endtask

    task automatic test_cb_jump;
        do_fetch(8'hCB, 8'd10);
        checks++;
        if ({oUpc, oUopValid, oIncPc} !== {8'd10, 2'b00}) begin errors++; $display("FAIL jcb_wait: upc=%0d v=%b i=%b need 10 0 0", oUpc, oUopValid, oIncPc); end
        tick;
        checks++;
        if (oUpc !== 8'd10) begin errors++; $display("FAIL jcb_wait_hold: upc=%0d need 10", oUpc); end
        iMemData = 8'h7C; iMemValid = 1;
        #1;
        checks++;
        if ({oUopValid, oIncPc, oEof, oCbMop} !== {3'b010, 8'h7C}) begin errors++; $display("FAIL jcb_go: v/i/e=%b%b%b cb=%h need 010 7c", oUopValid, oIncPc, oEof, oCbMop); end
        tick;
        iMemValid = 0;
        #1;
        checks++;
        if ({oUpc, oUopValid, oUpdFlags, oEof} !== {8'd16, 3'b111}) begin errors++; $display("FAIL cb_target: upc=%0d v/fu/e=%b%b%b need 16 111", oUpc, oUopValid, oUpdFlags, oEof); end
        tick;
        checks++;
        if (oFetchReq !== 1'b1) begin errors++; $display("FAIL cb_next_fetch: %b need 1", oFetchReq); end
    endtask

    task automatic test_stall;
        int incs = 0;
        do_fetch(8'h31, 8'd1);
        tick;
        for (int i = 0; i < 3; i++) begin
            iStall = 1;
            #1;
            checks++;
            if ({oUpc, oUopValid, oIncPc, oEof} !== {8'd2, 3'b000}) begin errors++; $display("FAIL stall[%0d]: upc=%0d v/i/e=%b%b%b need 2 000", i, oUpc, oUopValid, oIncPc, oEof); end
            tick;
        end
        iStall = 0;
        #1;
        incs += int'(oIncPc);
        checks++;
        if ({oUpc, oUopValid, oIncPc} !== {8'd2, 2'b11}) begin errors++; $display("FAIL stall_release: upc=%0d v/i=%b%b need 2 11", oUpc, oUopValid, oIncPc); end
        tick;
        incs += int'(oIncPc);
        checks++;
        if (oUpc !== 8'd3 || incs != 1) begin errors++; $display("FAIL stall_after: upc=%0d incs=%0d need 3 1", oUpc, incs); end
        tick; tick;
        checks++;
        if (oFetchReq !== 1'b1) begin errors++; $display("FAIL stall_next_fetch: %b need 1", oFetchReq); end
    endtask

    task automatic test_unknown_flow;
        do_fetch(8'h40, 8'd5);
        checks++;
        if ({oUopValid, oIncPc, oEof, oUpdFlags} !== 4'b1000) begin errors++; $display("FAIL unknown_flow: v/i/e/fu=%b%b%b%b need 1000", oUopValid, oIncPc, oEof, oUpdFlags); end
        tick;
        checks++;
        if ({oUpc, oEof} !== {8'd6, 1'b1}) begin errors++; $display("FAIL unknown_next: upc=%0d e=%b need 6 1", oUpc, oEof); end
        tick;
    endtask

    task automatic test_reset_mid;
        do_fetch(8'h31, 8'd1);
        iReset = 0;
        #1;
        checks++;
        if ({oUopValid, oIncPc, oEof, oFetchReq} !== 4'b0000) begin errors++; $display("FAIL reset_mid_strobes: v/i/e/f=%b%b%b%b need 0000", oUopValid, oIncPc, oEof, oFetchReq); end
        tick;
        iReset = 1;
        #1;
        checks++;
        if ({oFetchReq, oUpc} !== {1'b1, 8'd0}) begin errors++; $display("FAIL reset_mid_state: f=%b upc=%0d need 1 0", oFetchReq, oUpc); end
    endtask

    task automatic test_watchdog;
        int n = 0;
        logic hit = 0;
        do_reset;
        all_op = 1;
        do_fetch(8'h00, 8'd100);
        for (int k = 0; k < 40 && !hit; k++) begin
            if (oUopValid) n++;
            if (oEof) hit = 1; else tick;
        end
        checks++;
        if (!hit || n != 32 || oUpc !== 8'd131) begin errors++; $display("FAIL wd_count: hit=%b uops=%0d upc=%0d need 1 32 131", hit, n, oUpc); end
        checks++;
        if (oUcodeErr !== 1'b0) begin errors++; $display("FAIL wd_err_early: %b need 0", oUcodeErr); end
        tick;
        checks++;
        if ({oUcodeErr, oFetchReq} !== 2'b11) begin errors++; $display("FAIL wd_abort: err/f=%b%b need 11", oUcodeErr, oFetchReq); end
        all_op = 0;
        do_fetch(8'h31, 8'd1);
        tick; tick; tick; tick;
        checks++;
        if ({oUcodeErr, oFetchReq} !== 2'b11) begin errors++; $display("FAIL wd_err_sticky: err/f=%b%b need 11", oUcodeErr, oFetchReq); end
    endtask

    task automatic test_wrap;
        int n = 0;
        logic hit = 0;
        do_reset;
        all_op = 1;
        do_fetch(8'h00, 8'd250);
        for (int k = 0; k < 20 && !hit; k++) begin
            if (oUopValid) n++;
            if (oEof) hit = 1; else tick;
        end
        checks++;
        if (!hit || n != 6 || oUpc !== 8'd255) begin errors++; $display("FAIL wrap_count: hit=%b uops=%0d upc=%0d need 1 6 255", hit, n, oUpc); end
        tick;
        checks++;
        if ({oUcodeErr, oFetchReq} !== 2'b11) begin errors++; $display("FAIL wrap_abort: err/f=%b%b need 11", oUcodeErr, oFetchReq); end
        all_op = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = mk(F_EOF, i);
        rom[1]  = mk(F_INC, 1);
        rom[2]  = mk(F_INC, 2);
        rom[3]  = mk(F_OP, 3);
        rom[4]  = mk(F_INC_EOF, 4);
        rom[5]  = mk(4'hF, 5);
        rom[6]  = mk(F_EOF, 6);
        rom[10] = mk(F_JCB, 10);
        rom[16] = mk(F_EOF_FU, 16);
        rom[19] = mk(F_INC_EOF_Z, 19);
        rom[20] = mk(F_OP, 20);
        rom[21] = mk(F_OP, 21);
        rom[22] = mk(F_EOF, 22);
        test_reset;
        test_basic_seq;
        test_cond_eof;
        test_cb_jump;
        test_stall;
        test_unknown_flow;
        test_reset_mid;
        test_watchdog;
        test_wrap;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
